// File: rtl/led_cmd_sequencer_pkg.sv
// led_cmd_sequencer_pkg: shared LED command encodings, FSM states and pattern defaults
package led_cmd_sequencer_pkg;
    localparam int NUM_BTNS = 9;
    localparam int TICK_W = 6;
    localparam int MAX_TICKS = (1 << TICK_W) - 1;
    localparam int DEF_PAT_A_TICKS = 45;
    localparam int DEF_PAT_B_TICKS = 20;
    localparam logic [1:0] CMD_OFF = 2'b00;
    localparam logic [1:0] CMD_ON = 2'b01;
    localparam logic [1:0] CMD_PAT_A = 2'b10;
    localparam logic [1:0] CMD_PAT_B = 2'b11;
    typedef enum logic [1:0] {IDLE, PAT_A, PAT_B} state_t;
    function automatic logic [1:0] press_cmd(input logic [3:0] p);
        return p[0] ? CMD_OFF : p[1] ? CMD_ON : p[2] ? CMD_PAT_A : CMD_PAT_B;
    endfunction
endpackage

// File: rtl/led_cmd_sequencer_debounce.sv
// button_debounce: 2-FF synchroniser, stability counter and registered rise pulse for one button
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 240_000
) (
    input  logic hwclk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic s1, s2, level_q;
    logic [CW-1:0] cnt;
    // Accept the synced level once it has differed for DEBOUNCE_CYCLES cycles; pulse a cycle after a rise
    always_ff @(posedge hwclk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            level <= 1'b0;
            level_q <= 1'b0;
            press <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            level_q <= level;
            press <= level & ~level_q;
            if (s2 == level) cnt <= '0;
            else if (cnt == LAST) begin
                level <= s2;
                cnt <= '0;
            end else cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/led_cmd_sequencer.sv
// led_cmd_sequencer: debounces buttons and issues LED commands, holding timed patterns with busy
module led_cmd_sequencer
    import led_cmd_sequencer_pkg::*;
#(
    parameter int CLK_HZ = 12_000_000,
    parameter int DEBOUNCE_CYCLES = 240_000,
    parameter int TICK_CYCLES = 1_200_000,
    parameter int PAT_A_TICKS = DEF_PAT_A_TICKS,
    parameter int PAT_B_TICKS = DEF_PAT_B_TICKS
) (
    input  logic                hwclk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btns_raw,
    output logic [NUM_BTNS-1:0] btns_db,
    output logic [1:0]          cmd,
    output logic                busy
);
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

    if (CLK_HZ < 1 || DEBOUNCE_CYCLES < 1 || TICK_CYCLES < 1 ||
        PAT_A_TICKS < 1 || PAT_A_TICKS > MAX_TICKS ||
        PAT_B_TICKS < 1 || PAT_B_TICKS > MAX_TICKS) begin : g_bad_params
        $error("led_cmd_sequencer: pattern tick counts must be 1..63 and timing parameters positive");
    end

    logic [NUM_BTNS-1:0] press;
    logic unused_press;
    state_t state;
    logic [PW-1:0] pre;
    logic [TICK_W-1:0] remaining;
    logic wrap;

    assign unused_press = ^press[NUM_BTNS-1:4];
    assign wrap = pre == PRE_LAST;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .hwclk(hwclk),
            .rst(rst),
            .raw(btns_raw[i]),
            .level(btns_db[i]),
            .press(press[i])
        );
    end

    // Dispatch presses from IDLE; hold patterns until their tick budget runs out or button 0 aborts
    always_ff @(posedge hwclk) begin
        if (rst) begin
            state <= IDLE;
            cmd <= CMD_OFF;
            busy <= 1'b0;
            pre <= '0;
            remaining <= '0;
        end else if (state == IDLE) begin
            pre <= '0;
            if (|press[3:0]) cmd <= press_cmd(press[3:0]);
            if (press[1:0] == 2'b00 && press[2]) begin
                state <= PAT_A;
                busy <= 1'b1;
                remaining <= TICK_W'(PAT_A_TICKS);
            end else if (press[2:0] == 3'b000 && press[3]) begin
                state <= PAT_B;
                busy <= 1'b1;
                remaining <= TICK_W'(PAT_B_TICKS);
            end
        end else if (press[0] || (wrap && remaining == TICK_W'(1))) begin
            state <= IDLE;
            cmd <= CMD_OFF;
            busy <= 1'b0;
            pre <= '0;
        end else if (wrap) begin
            pre <= '0;
            remaining <= remaining - TICK_W'(1);
        end else pre <= pre + PW'(1);
    end
endmodule
